pipeline_ctrl: RTL

Central sequencing unit for the five-stage MIPS pipeline. Each cycle it decides which pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC advance, hold or flush. It resolves instruction-fetch waits, data-memory waits, load-use hazards, taken control transfers and halt. It also keeps cycle and stall performance counters.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/pctrl_counter.sv | 19 +
 rtl/pipeline_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
// Pipeline control state and register index types.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN,
    DWAIT,
    DDONE,
    HALT
  } pctrl_state_t;

  typedef logic [4:0] regbits_t;

endpackage

// File: rtl/pctrl_counter.sv
// Saturating event counter with enable.
// Sticks at all ones instead of wrapping.
module pctrl_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      cnt <= '0;
    else if (en && (cnt != '1))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencing: latch enables, flushes,
// memory waits, load-use bubbles, halt and perf counters.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             idex_dREN,
  input  regbits_t         idex_rt,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  input  logic             xfer_mem,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             imemREN,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  pctrl_state_t state, nxt;
  logic dpend, adv, lu;
  logic cyc_en, stall_en;

  assign dpend = exmem_dREN | exmem_dWEN;
  assign lu = idex_dREN && (idex_rt != '0) &&
              ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  always_comb begin
    nxt         = state;
    adv         = 1'b0;
    imemREN     = 1'b1;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    case (state)
      RUN: begin
        if (dpend)
          nxt = dhit ? DDONE : DWAIT;
        else
          adv = ihit;
      end
      DWAIT: begin
        if (dhit)
          nxt = DDONE;
      end
      DDONE: begin
        adv = ihit;
        if (ihit)
          nxt = RUN;
      end
      HALT: imemREN = 1'b0;
      default: nxt = RUN;
    endcase
    // halt beats xfer beats load-use
    if (adv) begin
      if (halt_mem) begin
        memwb_en = 1'b1;
        nxt      = HALT;
      end else if (xfer_mem) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (lu) begin
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end
    if (!nRST) begin
      imemREN     = 1'b1;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      state  <= nxt;
      halted <= (nxt == HALT);
    end
  end

  assign cyc_en   = (state != HALT);
  assign stall_en = cyc_en & ~pc_en;

  pctrl_counter #(.W(CNT_W)) u_cyc (
    .CLK  (CLK),
    .nRST (nRST),
    .en   (cyc_en),
    .cnt  (cyc_cnt)
  );

  pctrl_counter #(.W(CNT_W)) u_stall (
    .CLK  (CLK),
    .nRST (nRST),
    .en   (stall_en),
    .cnt  (stall_cnt)
  );

endmodule
